// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline: word load/store on a local data RAM,
// optional multi-cycle access latency with upstream stall, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register_ex,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    input  logic        zero,
    output logic        pc_src,
    output logic        stall_mem,
    output logic        mis_align,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb,
    output logic [4:0]  rd_WB,
    output logic [1:0]  wb_WB,
    output logic [31:0] write_data_reg
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          mis;
    logic          aligned_acc;
    logic          access;
    logic [AW-1:0] idx;
    logic [31:0]   ram [DEPTH];

    assign acc         = m_MEM[1] | m_MEM[0];
    assign mis         = acc & (res[1:0] != 2'b00);
    assign aligned_acc = acc & ~mis;
    assign idx         = res[AW+1:2];
    assign access      = aligned_acc & ~stall_mem & ~rst;

    assign pc_src         = m_MEM[2] & zero;
    assign write_data_reg = wb_WB[0] ? read_data_wb : alu_res_wb;

    // Stall is combinational so the freeze takes effect in the cycle the access is seen.
    always_comb begin
        stall_mem = 1'b0;
        if (!rst && MEM_LAT != 0) begin
            if (state == IDLE) begin
                stall_mem = aligned_acc;
            end else begin
                stall_mem = (cnt != CW'(MEM_LAT));
            end
        end
    end

    // Latency sequencer: counts wait cycles, completes the access when cnt reaches MEM_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aligned_acc && MEM_LAT != 0) begin
                        state <= WAIT;
                        cnt   <= CW'(1);
                    end
                end
                WAIT: begin
                    if (cnt == CW'(MEM_LAT)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Data RAM is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (access && m_MEM[0]) begin
            ram[idx] <= write_data_ex;
        end
    end

    // MEM/WB register: bubble while stalled, suppressed write-back on misalignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_WB        <= 2'b00;
            rd_WB        <= 5'd0;
            alu_res_wb   <= 32'd0;
            read_data_wb <= 32'd0;
            mis_align    <= 1'b0;
        end else if (stall_mem) begin
            wb_WB     <= 2'b00;
            mis_align <= 1'b0;
        end else begin
            alu_res_wb <= res;
            rd_WB      <= write_register_ex;
            mis_align  <= mis;
            wb_WB      <= mis ? 2'b00 : wb_MEM;
            if (access && m_MEM[1] && !m_MEM[0]) begin
                read_data_wb <= ram[idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: two instances (single-cycle and 2-wait-cycle RAM),
// directed cases plus random instructions checked against a per-instruction reference model.
module tb_mem_stage;

    localparam int unsigned LAT0 = 0;
    localparam int unsigned LAT1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic [31:0] res   [2];
    logic [31:0] wdata [2];
    logic [4:0]  wreg  [2];
    logic [2:0]  m     [2];
    logic [1:0]  wb    [2];
    logic        zero  [2];

    logic        pc_src [2];
    logic        stall  [2];
    logic        misal  [2];
    logic [31:0] rdat   [2];
    logic [31:0] alu    [2];
    logic [4:0]  rdwb   [2];
    logic [1:0]  wbwb   [2];
    logic [31:0] wdr    [2];

    mem_stage #(.DEPTH(1024), .MEM_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst[0]), .res(res[0]), .write_data_ex(wdata[0]),
        .write_register_ex(wreg[0]), .m_MEM(m[0]), .wb_MEM(wb[0]), .zero(zero[0]),
        .pc_src(pc_src[0]), .stall_mem(stall[0]), .mis_align(misal[0]),
        .read_data_wb(rdat[0]), .alu_res_wb(alu[0]), .rd_WB(rdwb[0]), .wb_WB(wbwb[0]),
        .write_data_reg(wdr[0])
    );

    mem_stage #(.DEPTH(1024), .MEM_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst[1]), .res(res[1]), .write_data_ex(wdata[1]),
        .write_register_ex(wreg[1]), .m_MEM(m[1]), .wb_MEM(wb[1]), .zero(zero[1]),
        .pc_src(pc_src[1]), .stall_mem(stall[1]), .mis_align(misal[1]),
        .read_data_wb(rdat[1]), .alu_res_wb(alu[1]), .rd_WB(rdwb[1]), .wb_WB(wbwb[1]),
        .write_data_reg(wdr[1])
    );

    typedef struct {
        logic        stall;
        logic        pc;
        logic        mis;
        logic [1:0]  wb;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: memory image and the MEM/WB fields that hold across bubbles.
    logic [31:0] mdl   [2][1024];
    logic [4:0]  h_rd  [2];
    logic [31:0] h_alu [2];
    logic [31:0] h_rdat[2];

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // One instruction: held for as many cycles as the stage needs, one expected entry per cycle.
    task automatic issue(input int d, input logic [31:0] r, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [2:0] mm, input logic [1:0] w,
                         input logic z);
        int          lat;
        int          n;
        bit          a;
        bit          mi;
        int unsigned ix;
        exp_t        e;
        lat = (d == 0) ? int'(LAT0) : int'(LAT1);
        a   = (mm[1] | mm[0]);
        mi  = a && (r[1:0] != 2'b00);
        ix  = 32'(r[11:2]);
        n   = (a && !mi) ? lat + 1 : 1;
        res[d] = r; wdata[d] = wd; wreg[d] = rd; m[d] = mm; wb[d] = w; zero[d] = z;
        for (int c = 0; c < n; c++) begin
            e.stall = (c < n - 1);
            e.pc    = mm[2] & z;
            e.mis   = 1'b0;
            e.wb    = 2'b00;
            if (!e.stall) begin
                h_rd[d]  = rd;
                h_alu[d] = r;
                if (mi) begin
                    e.mis = 1'b1;
                end else begin
                    e.wb = w;
                    if (a && mm[1] && !mm[0]) h_rdat[d] = mdl[d][ix];
                    if (a && mm[0])           mdl[d][ix] = wd;
                end
            end
            e.rd = h_rd[d]; e.alu = h_alu[d]; e.rdat = h_rdat[d];
            push(d, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_entry(input int d);
        exp_t e;
        h_rd[d] = 5'd0; h_alu[d] = 32'd0; h_rdat[d] = 32'd0;
        e.stall = 1'b0; e.pc = m[d][2] & zero[d]; e.mis = 1'b0; e.wb = 2'b00;
        e.rd = 5'd0; e.alu = 32'd0; e.rdat = 32'd0;
        push(d, e);
    endtask

    task automatic rand_instr(input int d);
        logic [31:0] tmp;
        logic [31:0] r;
        logic [2:0]  mm;
        logic [9:0]  ix;
        case ($urandom_range(0, 5))
            0: mm = 3'b000;
            1: mm = 3'b010;
            2: mm = 3'b001;
            3: mm = 3'b011;
            4: mm = 3'b100;
            default: mm = 3'b110;
        endcase
        tmp = $urandom();
        ix  = 10'($urandom_range(0, 15));
        if (mm[1] | mm[0]) begin
            r = {tmp[31:12], ix, 2'b00};
            if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(1, 3));
        end else begin
            r = tmp;
        end
        issue(d, r, $urandom(), 5'($urandom_range(0, 31)), mm,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    // Monitor: stall/pc_src sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t cur [2];
        bit   v   [2];
        logic s_st[2];
        logic s_pc[2];
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                v[d] = 1'b0;
                if (d == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); v[0] = 1'b1; end
                if (d == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); v[1] = 1'b1; end
                s_st[d] = stall[d];
                s_pc[d] = pc_src[d];
            end
            @(posedge clk); #2;
            for (int d = 0; d < 2; d++) begin
                if (v[d]) begin
                    chk($sformatf("d%0d stall_mem", d), 32'(s_st[d]), 32'(cur[d].stall));
                    chk($sformatf("d%0d pc_src", d), 32'(s_pc[d]), 32'(cur[d].pc));
                    chk($sformatf("d%0d mis_align", d), 32'(misal[d]), 32'(cur[d].mis));
                    chk($sformatf("d%0d wb_WB", d), 32'(wbwb[d]), 32'(cur[d].wb));
                    chk($sformatf("d%0d rd_WB", d), 32'(rdwb[d]), 32'(cur[d].rd));
                    chk($sformatf("d%0d alu_res_wb", d), alu[d], cur[d].alu);
                    chk($sformatf("d%0d read_data_wb", d), rdat[d], cur[d].rdat);
                    chk($sformatf("d%0d write_data_reg", d), wdr[d],
                        cur[d].wb[0] ? cur[d].rdat : cur[d].alu);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; res[d] = '0; wdata[d] = '0; wreg[d] = '0;
            m[d] = '0; wb[d] = '0; zero[d] = 1'b0;
        end
        @(posedge clk); #1;
        reset_entry(0);
        reset_entry(1);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++)
                issue(d, 32'(i * 4), $urandom(), 5'd0, 3'b001, 2'b00, 1'b0);
            issue(d, 32'h10, 32'hDEADBEEF, 5'd0, 3'b001, 2'b00, 1'b0);
            issue(d, 32'h10, 32'h0, 5'd8, 3'b010, 2'b11, 1'b0);
            issue(d, 32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0);
            issue(d, 32'h12, 32'h0, 5'd9, 3'b010, 2'b11, 1'b0);
            issue(d, 32'h16, 32'h12345678, 5'd0, 3'b001, 2'b00, 1'b0);
            issue(d, 32'h14, 32'h0, 5'd10, 3'b010, 2'b11, 1'b0);
            issue(d, 32'h55, 32'h0, 5'd3, 3'b000, 2'b10, 1'b0);
            issue(d, 32'h0, 32'h0, 5'd0, 3'b100, 2'b00, 1'b1);
            issue(d, 32'h0, 32'h0, 5'd0, 3'b100, 2'b00, 1'b0);
            issue(d, 32'h1000, 32'hCAFEF00D, 5'd0, 3'b001, 2'b00, 1'b0);
            issue(d, 32'h0, 32'h0, 5'd4, 3'b010, 2'b11, 1'b0);
            issue(d, 32'h8, 32'h0BADF00D, 5'd7, 3'b011, 2'b11, 1'b0);
            issue(d, 32'h8, 32'h0, 5'd7, 3'b010, 2'b11, 1'b0);
            if (d == 1) begin
                // Store aborted by reset in its second stall cycle must not reach the RAM.
                exp_t e;
                res[1] = 32'h20; wdata[1] = 32'h55AA55AA; wreg[1] = 5'd0;
                m[1] = 3'b001; wb[1] = 2'b00; zero[1] = 1'b0;
                e.stall = 1'b1; e.pc = 1'b0; e.mis = 1'b0; e.wb = 2'b00;
                e.rd = h_rd[1]; e.alu = h_alu[1]; e.rdat = h_rdat[1];
                push(1, e);
                @(posedge clk); #1;
                rst[1] = 1'b1;
                reset_entry(1);
                @(posedge clk); #1;
                rst[1] = 1'b0;
                issue(1, 32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0);
                issue(1, 32'h20, 32'h0, 5'd11, 3'b010, 2'b11, 1'b0);
            end
            for (int i = 0; i < 150; i++) rand_instr(d);
            issue(d, 32'h0, 32'h0, 5'd0, 3'b000, 2'b00, 1'b0);
        end

        repeat (4) @(posedge clk);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
